// File: rtl/sys1_clken_gen.sv
// sys1_clken_gen: clock-enable generator for the SEGA System 1/2 core (clk48M domain).
//
// Purpose:
//   - Power-of-two divider chain: square outputs div_clk[i] = clk48M/2^(i+1) plus
//     one-cycle enables div_ce[i] that pulse on the same edge where div_clk[i] falls.
//   - NCH runtime-programmable fractional channels (num/den of clk48M) producing a
//     one-cycle enable frac_ce[c] and a toggle output frac_clk[c].
//
// Ports:
//   clk48M    in   master clock
//   reset     in   asynchronous reset, active-high
//   pause     in   freeze counters, force enables low (only with CLKGEN_PAUSE_EN)
//   cfg_we    in   load strobe for channel cfg_ch (ignored when cfg_ch >= NCH)
//   cfg_ch    in   channel index
//   cfg_num   in   numerator to load
//   cfg_den   in   denominator to load
//   div_clk   out  divider counter bits
//   div_ce    out  divider enables
//   frac_ce   out  fractional enables
//   frac_clk  out  fractional toggle outputs
//
// Optional feature macro: CLKGEN_PAUSE_EN (adds the pause port).
// All outputs are registered.

module sys1_clken_gen #(
  parameter int unsigned DIVW    = 5,
  parameter int unsigned NCH     = 2,
  parameter int unsigned ACCW    = 8,
  parameter int unsigned RST_NUM = 1,
  parameter int unsigned RST_DEN = 3,
  localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk48M,
  input  logic            reset,
`ifdef CLKGEN_PAUSE_EN
  input  logic            pause,
`endif
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [ACCW-1:0] cfg_num,
  input  logic [ACCW-1:0] cfg_den,
  output logic [DIVW-1:0] div_clk,
  output logic [DIVW-1:0] div_ce,
  output logic [NCH-1:0]  frac_ce,
  output logic [NCH-1:0]  frac_clk
);

  logic run;
`ifdef CLKGEN_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  // Divider chain
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] div_ce_q, div_ce_d;

  always_comb begin
    logic ones;
    cnt_d    = cnt_q;
    div_ce_d = '0;
    ones     = 1'b1;
    if (run) begin
      cnt_d = cnt_q + 1'b1;
      // div_ce[i] fires on the edge that carries counter[i:0] out of all-ones.
      for (int i = 0; i < DIVW; i++) begin
        ones        = ones & cnt_q[i];
        div_ce_d[i] = ones;
      end
    end
  end

  // Fractional channels
  logic [ACCW-1:0] num_q [NCH];
  logic [ACCW-1:0] num_d [NCH];
  logic [ACCW-1:0] den_q [NCH];
  logic [ACCW-1:0] den_d [NCH];
  logic [ACCW-1:0] acc_q [NCH];
  logic [ACCW-1:0] acc_d [NCH];
  logic [NCH-1:0]  fce_q, fce_d;
  logic [NCH-1:0]  fclk_q, fclk_d;

  always_comb begin
    logic [ACCW:0] sum;
    num_d  = num_q;
    den_d  = den_q;
    acc_d  = acc_q;
    fce_d  = '0;
    fclk_d = fclk_q;
    sum    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_we && (cfg_ch == CHW'(c))) begin
        // Load wins over this cycle's update, even while paused.
        num_d[c]  = cfg_num;
        den_d[c]  = cfg_den;
        acc_d[c]  = '0;
        fclk_d[c] = 1'b0;
      end else if (!run || (num_q[c] == '0) || (den_q[c] == '0)) begin
        fce_d[c] = 1'b0;
      end else if (num_q[c] >= den_q[c]) begin
        acc_d[c]  = '0;
        fce_d[c]  = 1'b1;
        fclk_d[c] = ~fclk_q[c];
      end else begin
        sum = {1'b0, acc_q[c]} + {1'b0, num_q[c]};
        if (sum >= {1'b0, den_q[c]}) begin
          acc_d[c]  = ACCW'(sum - {1'b0, den_q[c]});
          fce_d[c]  = 1'b1;
          fclk_d[c] = ~fclk_q[c];
        end else begin
          acc_d[c] = sum[ACCW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      div_ce_q <= '0;
      fce_q    <= '0;
      fclk_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        num_q[c] <= ACCW'(RST_NUM);
        den_q[c] <= ACCW'(RST_DEN);
        acc_q[c] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      div_ce_q <= div_ce_d;
      fce_q    <= fce_d;
      fclk_q   <= fclk_d;
      for (int c = 0; c < NCH; c++) begin
        num_q[c] <= num_d[c];
        den_q[c] <= den_d[c];
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign div_clk  = cnt_q;
  assign div_ce   = div_ce_q;
  assign frac_ce  = fce_q;
  assign frac_clk = fclk_q;

endmodule

// File: tb/tb_sys1_clken_gen.sv
// tb_sys1_clken_gen: randomized self-checking bench for sys1_clken_gen.
// The reference model counts edges: divider state is the number of running edges,
// a fractional channel pulses whenever floor(k*num/den) advances, k counting updates
// since the last load. Built with NCH=3 so that an out-of-range cfg_ch is encodable.

module tb_sys1_clken_gen;

  localparam int unsigned DIVW = 5;
  localparam int unsigned NCH  = 3;
  localparam int unsigned ACCW = 8;
  localparam int unsigned CHW  = 2;

  logic            clk48M = 1'b0;
  logic            reset;
`ifdef CLKGEN_PAUSE_EN
  logic            pause;
`endif
  logic            cfg_we;
  logic [CHW-1:0]  cfg_ch;
  logic [ACCW-1:0] cfg_num;
  logic [ACCW-1:0] cfg_den;
  logic [DIVW-1:0] div_clk;
  logic [DIVW-1:0] div_ce;
  logic [NCH-1:0]  frac_ce;
  logic [NCH-1:0]  frac_clk;

  sys1_clken_gen #(
    .DIVW    (DIVW),
    .NCH     (NCH),
    .ACCW    (ACCW),
    .RST_NUM (1),
    .RST_DEN (3)
  ) u_dut (
    .clk48M   (clk48M),
    .reset    (reset),
`ifdef CLKGEN_PAUSE_EN
    .pause    (pause),
`endif
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .div_clk  (div_clk),
    .div_ce   (div_ce),
    .frac_ce  (frac_ce),
    .frac_clk (frac_clk)
  );

  always #5 clk48M = ~clk48M;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int m_n;
  int m_dce;
  int m_num [NCH];
  int m_den [NCH];
  int m_k   [NCH];
  int m_p   [NCH];
  bit m_ce  [NCH];

  task automatic model_reset();
    m_n   = 0;
    m_dce = 0;
    for (int c = 0; c < NCH; c++) begin
      m_num[c] = 1;
      m_den[c] = 3;
      m_k[c]   = 0;
      m_p[c]   = 0;
      m_ce[c]  = 1'b0;
    end
  endtask

  task automatic model_step();
    bit pz;
    int kk;
    pz = 1'b0;
`ifdef CLKGEN_PAUSE_EN
    pz = pause;
`endif
    m_dce = 0;
    if (!pz) begin
      m_n++;
      for (int i = 0; i < DIVW; i++)
        if (m_n % (1 << (i + 1)) == 0) m_dce |= (1 << i);
    end
    for (int c = 0; c < NCH; c++) begin
      if (cfg_we && int'(cfg_ch) == c) begin
        m_num[c] = int'(cfg_num);
        m_den[c] = int'(cfg_den);
        m_k[c]   = 0;
        m_p[c]   = 0;
        m_ce[c]  = 1'b0;
      end else if (pz || m_num[c] == 0 || m_den[c] == 0) begin
        m_ce[c] = 1'b0;
      end else if (m_num[c] >= m_den[c]) begin
        m_ce[c] = 1'b1;
        m_p[c]++;
      end else begin
        kk      = m_k[c] + 1;
        m_ce[c] = ((kk * m_num[c]) / m_den[c]) != ((m_k[c] * m_num[c]) / m_den[c]);
        if (m_ce[c]) m_p[c]++;
        m_k[c] = kk % m_den[c];
      end
    end
  endtask

  function automatic int unsigned exp_fce();
    int unsigned v = 0;
    for (int c = 0; c < NCH; c++) if (m_ce[c]) v |= (1 << c);
    return v;
  endfunction

  function automatic int unsigned exp_fclk();
    int unsigned v = 0;
    for (int c = 0; c < NCH; c++) if (m_p[c] % 2 == 1) v |= (1 << c);
    return v;
  endfunction

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk48M);
    model_step();
    @(negedge clk48M);
    check("div_clk", div_clk, m_n % (1 << DIVW));
    check("div_ce", div_ce, m_dce);
    check("frac_ce", frac_ce, exp_fce());
    check("frac_clk", frac_clk, exp_fclk());
  endtask

  task automatic idle_inputs();
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_num = '0;
    cfg_den = '0;
`ifdef CLKGEN_PAUSE_EN
    pause   = 1'b0;
`endif
  endtask

  task automatic load(input int ch, input int num, input int den);
    cfg_we  = 1'b1;
    cfg_ch  = CHW'(ch);
    cfg_num = ACCW'(num);
    cfg_den = ACCW'(den);
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_div_clk"}, div_clk, 0);
    check({tag, "_div_ce"}, div_ce, 0);
    check({tag, "_frac_ce"}, frac_ce, 0);
    check({tag, "_frac_clk"}, frac_clk, 0);
  endtask

  // Fixed-expectation run right after reset release with default 1/3 channels.
  task automatic default_pattern(input string tag);
    for (int e = 1; e <= 40; e++) begin
      tick();
      check({tag, "_div0"}, div_clk[0], e % 2);
      check({tag, "_dce2"}, div_ce[2], (e % 8 == 0) ? 1 : 0);
      check({tag, "_fce0"}, frac_ce[0], (e % 3 == 0) ? 1 : 0);
      check({tag, "_fce1"}, frac_ce[1], (e % 3 == 0) ? 1 : 0);
      check({tag, "_fclk0"}, frac_clk[0], ((e / 3) % 2 == 1) ? 1 : 0);
      if (e == 32) check({tag, "_wrap"}, div_clk, 0);
    end
  endtask

  initial begin
    int cnt;
    int phase;
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #12;
    check_zero_outputs("rst");
    @(negedge clk48M);
    reset = 1'b0;

    default_pattern("def");

    // 3/8 on channel 1: pulses on the 3rd, 6th and 8th edge of each period
    load(1, 3, 8);
    cnt = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      phase = e % 8;
      check("ch1_3of8", frac_ce[1], (phase == 3 || phase == 6 || phase == 0) ? 1 : 0);
      cnt += int'(frac_ce[1]);
    end
    check("ch1_3of8_count", cnt, 6);

    // num >= den: enable every cycle
    load(0, 5, 4);
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("ch0_full", frac_ce[0], 1);
      check("ch0_full_clk", frac_clk[0], e % 2);
    end
    // num = 0: channel disabled, frac_clk held at its load value
    load(0, 0, 7);
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("ch0_off", frac_ce[0], 0);
      check("ch0_off_clk", frac_clk[0], 0);
    end
    // Out-of-range channel index is ignored (model verifies no channel changes)
    load(3, 1, 1);
    for (int e = 0; e < 12; e++) tick();

`ifdef CLKGEN_PAUSE_EN
    load(2, 2, 5);
    for (int e = 0; e < 7; e++) tick();
    pause = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("pause_dce", div_ce, 0);
      check("pause_fce", frac_ce, 0);
      if (e == 4) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_num = 8'd1; cfg_den = 8'd2;
      end else begin
        cfg_we = 1'b0;
      end
    end
    pause = 1'b0;
    for (int e = 0; e < 20; e++) tick();
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_ch = CHW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        cfg_num = ACCW'($urandom);
        cfg_den = ACCW'($urandom);
      end else begin
        cfg_num = ACCW'($urandom_range(0, 9));
        cfg_den = ACCW'($urandom_range(0, 12));
      end
`ifdef CLKGEN_PAUSE_EN
      pause = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    idle_inputs();
    for (int e = 0; e < 5; e++) tick();

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(negedge clk48M);
    reset = 1'b0;
    default_pattern("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
